// File: rtl/fifo_rr_scheduler_pkg.sv
// Shared definitions for the round-robin FIFO write scheduler.
//   NUM_REQ_DEF / DATA_W_DEF / FIFO_DEPTH_DEF : default configuration
//   MAX_REQ                                    : widest producer vector rr_pick accepts
//   src_id_t                                   : producer index type for the default config
//   rr_pick(req, ptr, n)                       : round-robin search helper
package fifo_sched_pkg;

  localparam int unsigned NUM_REQ_DEF    = 4;
  localparam int unsigned DATA_W_DEF     = 4;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned MAX_REQ        = 8;
  localparam int unsigned SRC_W_DEF      = $clog2(NUM_REQ_DEF);

  typedef logic [SRC_W_DEF-1:0] src_id_t;

  // Returns the first index i with req[i] set, searching ptr, ptr+1, ...
  // and wrapping at n-1 -> 0. Returns n when nothing is requesting.
  // ptr must be below n; only the low n bits of req are examined.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] req,
                                          input int unsigned        ptr,
                                          input int unsigned        n);
    int unsigned idx;
    logic        found;
    rr_pick = n;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n && !found) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        // shift-and-test keeps the select free of a variable bit index
        if (((req >> idx) & MAX_REQ'(1)) != '0) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/fifo_rr_scheduler_if.sv
// Bundle of the producer, FIFO and output-stream handshakes around the
// scheduler.
//   master : scheduler view (drives grants, FIFO strobes, output word)
//   slave  : environment view (producers, FIFO, downstream consumer)
interface fifo_rr_scheduler_if
  import fifo_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
);
  localparam int unsigned SRC_W = $clog2(NUM_REQ);

  // producers
  logic [NUM_REQ-1:0]        req_vld;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_rdy;
  // FIFO ports
  logic                      write_en;
  logic [DATA_W-1:0]         write_data;
  logic                      full;
  logic                      empty;
  logic                      read_en;
  logic [DATA_W-1:0]         read_data;
  // output stream
  logic                      out_vld;
  logic [DATA_W-1:0]         out_data;
  logic [SRC_W-1:0]          out_src;
  logic                      out_rdy;

  modport master (
    input  req_vld, req_data, full, empty, read_data, out_rdy,
    output req_rdy, write_en, write_data, read_en, out_vld, out_data, out_src
  );

  modport slave (
    output req_vld, req_data, full, empty, read_data, out_rdy,
    input  req_rdy, write_en, write_data, read_en, out_vld, out_data, out_src
  );

endinterface

// File: rtl/fifo_rr_scheduler_arbiter.sv
// Round-robin pick logic with its rotating priority pointer.
//   clk, rstN  : clock, asynchronous active-low reset (pointer -> 0)
//   req        : per-producer request vector
//   can_wr     : a write may be issued this cycle
//   grant      : one-hot grant, or zero
//   grant_idx  : index of the granted producer (meaningful when |grant)
module rr_arbiter
  import fifo_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
  localparam int unsigned SRC_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic [NUM_REQ-1:0] req,
  input  logic               can_wr,
  output logic [NUM_REQ-1:0] grant,
  output logic [SRC_W-1:0]   grant_idx
);

  logic [SRC_W-1:0] ptr;
  int unsigned      pick;
  logic             hit;

  always_comb begin
    pick      = rr_pick(MAX_REQ'(req), 32'(ptr), NUM_REQ);
    hit       = (pick < NUM_REQ) && can_wr;
    grant_idx = SRC_W'(pick);
    grant     = '0;
    if (hit) grant = NUM_REQ'(1) << pick;
  end

  // NUM_REQ need not be a power of two, so the wrap is explicit.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ptr <= '0;
    end else if (hit) begin
      ptr <= (pick == NUM_REQ - 1) ? '0 : SRC_W'(pick + 1);
    end
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Shares one FIFO between NUM_REQ producers: a round-robin write scheduler
// feeds the FIFO, a read sequencer pops it into a registered valid/ready
// output stage, and a shadow queue tags each word with its producer index.
//   clk, rstN : clock, asynchronous active-low reset
//   cfg_en    : 1 = new grants allowed (draining continues regardless)
//   bus       : producer / FIFO / output handshakes (master view)
//   idle      : nothing in the FIFO and no output word pending
//   sync_err  : sticky, shadow occupancy disagreed with FIFO full/empty
module fifo_rr_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 cfg_en,
  fifo_rr_scheduler_if.master  bus,
  output logic                 idle,
  output logic                 sync_err
);

  localparam int unsigned SRC_W = $clog2(NUM_REQ);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic                 read_en;
  logic                 can_wr;
  logic                 write_en;
  logic [NUM_REQ-1:0]   grant;
  logic [SRC_W-1:0]     grant_idx;
  logic [DATA_W-1:0]    write_data;

  logic [SRC_W-1:0]     shq [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;

  logic                 out_vld;
  logic [DATA_W-1:0]    out_data;
  logic [SRC_W-1:0]     out_src;

  // Strobes are qualified by rstN so that no grant or pop is offered
  // while reset is held, regardless of what the FIFO flags show.
  always_comb begin
    read_en = rstN && !bus.empty && (!out_vld || bus.out_rdy);
    can_wr  = rstN && cfg_en && (!bus.full || read_en);
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .rstN      (rstN),
    .req       (bus.req_vld),
    .can_wr    (can_wr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    write_en   = |grant;
    write_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) write_data = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  // Shadow queue storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (write_en) shq[wr_ptr] <= grant_idx;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (write_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (read_en)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (write_en && !read_en)      count <= count + CNT_W'(1);
      else if (!write_en && read_en) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_src  <= '0;
    end else if (read_en) begin
      out_vld  <= 1'b1;
      out_data <= bus.read_data;
      out_src  <= shq[rd_ptr];
    end else if (bus.out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync_err <= 1'b0;
    end else if (((count == CNT_W'(FIFO_DEPTH)) != bus.full) ||
                 ((count == '0) != bus.empty)) begin
      sync_err <= 1'b1;
    end
  end

  always_comb begin
    idle           = (count == '0) && !out_vld;
    bus.req_rdy    = grant;
    bus.write_en   = write_en;
    bus.write_data = write_data;
    bus.read_en    = read_en;
    bus.out_vld    = out_vld;
    bus.out_data   = out_data;
    bus.out_src    = out_src;
  end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed scoreboard bench for fifo_rr_scheduler with a 4-entry FIFO model.
module tb_fifo_rr_scheduler;
  import fifo_sched_pkg::*;

  localparam int unsigned NR    = 4;
  localparam int unsigned DW    = 4;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic cfg_en = 1'b0;
  logic idle;
  logic sync_err;

  fifo_rr_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  fifo_rr_scheduler #(
    .NUM_REQ    (NR),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rstN     (rstN),
    .cfg_en   (cfg_en),
    .bus      (bus),
    .idle     (idle),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  // FIFO model, reset together with the scheduler
  logic [DW-1:0] fmem [DEPTH];
  logic [1:0]    fwp;
  logic [1:0]    frp;
  logic [2:0]    fcnt;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      fwp  <= '0;
      frp  <= '0;
      fcnt <= '0;
    end else begin
      if (bus.write_en) begin
        fmem[fwp] <= bus.write_data;
        fwp <= fwp + 2'd1;
      end
      if (bus.read_en) frp <= frp + 2'd1;
      if (bus.write_en && !bus.read_en)      fcnt <= fcnt + 3'd1;
      else if (!bus.write_en && bus.read_en) fcnt <= fcnt - 3'd1;
    end
  end

  assign bus.full      = (fcnt == 3'd4);
  assign bus.empty     = (fcnt == 3'd0);
  assign bus.read_data = fmem[frp];

  // scoreboard
  typedef struct {
    src_id_t       src;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic expect_word(input int src, input logic [DW-1:0] d);
    exp_t x;
    x.src  = src_id_t'(src);
    x.data = d;
    exp_q.push_back(x);
  endtask

  // monitor: a word is consumed on the edge following a valid&&ready sample
  always @(negedge clk) begin
    if (rstN && bus.out_vld && bus.out_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_word: got data 0x%0h src %0d, expected no word at %0t",
                 bus.out_data, bus.out_src, $time);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(bus.out_data), 32'(e.data));
        check("out_src",  32'(bus.out_src),  32'(e.src));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  logic [NR-1:0] t1_gnt [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  int            t1_src [6] = '{0, 1, 2, 3, 0, 1};
  logic [DW-1:0] t1_dat [6] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA, 4'hB};
  logic [DW-1:0] t2_dat [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
  logic [DW-1:0] t5_dat [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
  logic [DW-1:0] t6_dat [3] = '{4'hE, 4'hF, 4'h7};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bus.req_vld  = '0;
    bus.req_data = '0;
    bus.out_rdy  = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_vld",  32'(bus.out_vld),  32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_src",  32'(bus.out_src),  32'd0);
    check("rst_sync_err", 32'(sync_err),     32'd0);
    check("rst_req_rdy",  32'(bus.req_rdy),  32'd0);
    check("rst_write_en", 32'(bus.write_en), 32'd0);
    check("rst_read_en",  32'(bus.read_en),  32'd0);
    check("rst_idle",     32'(idle),         32'd1);
    #2 rstN = 1'b1;

    // 1: all producers requesting, full throughput, strict rotation
    bus.req_data = {4'hD, 4'hC, 4'hB, 4'hA};
    bus.req_vld  = 4'b1111;
    cfg_en       = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("t1_grant", 32'(bus.req_rdy),    32'(t1_gnt[k]));
      check("t1_wdata", 32'(bus.write_data), 32'(t1_dat[k]));
      expect_word(t1_src[k], t1_dat[k]);
      step();
    end
    bus.req_vld = '0;
    drain("t1_drain");
    check("t1_sync_err", 32'(sync_err), 32'd0);
    check("t1_idle",     32'(idle),     32'd1);

    // 2: back-pressure until the FIFO is full; output word held stable
    bus.out_rdy = 1'b0;
    bus.req_vld = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      bus.req_data = {4'h0, t2_dat[k], 8'h00};
      #1;
      check("t2_grant", 32'(bus.req_rdy), 32'b0100);
      expect_word(2, t2_dat[k]);
      step();
    end
    bus.req_data = {4'h0, 4'h6, 8'h00};
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t2_full_rdy",  32'(bus.req_rdy),  32'd0);
      check("t2_full_wen",  32'(bus.write_en), 32'd0);
      check("t2_hold_ren",  32'(bus.read_en),  32'd0);
      check("t2_hold_vld",  32'(bus.out_vld),  32'd1);
      check("t2_hold_data", 32'(bus.out_data), 32'h1);
      check("t2_hold_src",  32'(bus.out_src),  32'd2);
      step();
    end
    check("t2_sync_err", 32'(sync_err), 32'd0);
    check("t2_idle",     32'(idle),     32'd0);

    // 3: pop and push on the same edge while full
    bus.out_rdy  = 1'b1;
    bus.req_vld  = 4'b0010;
    bus.req_data = {8'h00, 4'h6, 4'h0};
    #1;
    check("t3_grant", 32'(bus.req_rdy),  32'b0010);
    check("t3_wen",   32'(bus.write_en), 32'd1);
    check("t3_ren",   32'(bus.read_en),  32'd1);
    expect_word(1, 4'h6);
    step();
    bus.req_vld = '0;
    #1;
    check("t3_sync_err", 32'(sync_err), 32'd0);
    drain("t3_drain");

    // 4: pointer skips idle producers, then wraps to 0
    bus.req_vld  = 4'b0001;
    bus.req_data = {12'h000, 4'h7};
    #1;
    check("t4_grant0", 32'(bus.req_rdy), 32'b0001);
    expect_word(0, 4'h7);
    step();
    bus.req_vld  = 4'b1000;
    bus.req_data = {4'h8, 12'h000};
    #1;
    check("t4_grant3", 32'(bus.req_rdy), 32'b1000);
    expect_word(3, 4'h8);
    step();
    bus.req_vld  = 4'b1111;
    bus.req_data = {4'h4, 4'h3, 4'h2, 4'h9};
    #1;
    check("t4_wrap",  32'(bus.req_rdy),    32'b0001);
    check("t4_wdata", 32'(bus.write_data), 32'h9);
    expect_word(0, 4'h9);
    step();
    bus.req_vld = '0;
    drain("t4_drain");

    // 5: cfg_en dropped with words queued; they drain, nothing new granted
    bus.out_rdy = 1'b0;
    bus.req_vld = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      bus.req_data = {8'h00, t5_dat[k], 4'h0};
      #1;
      check("t5_grant", 32'(bus.req_rdy), 32'b0010);
      expect_word(1, t5_dat[k]);
      step();
    end
    cfg_en      = 1'b0;
    bus.req_vld = 4'b1111;
    #1;
    check("t5_off_rdy", 32'(bus.req_rdy),  32'd0);
    check("t5_off_wen", 32'(bus.write_en), 32'd0);
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      step();
      check("t5_no_grant", 32'(bus.write_en), 32'd0);
    end
    check("t5_drain", 32'(exp_q.size()), 32'd0);
    check("t5_idle",  32'(idle),         32'd1);
    cfg_en      = 1'b1;
    bus.req_vld = '0;
    #1;

    // 6: asynchronous reset with words in flight
    bus.out_rdy = 1'b0;
    bus.req_vld = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      bus.req_data = {4'h0, t6_dat[k], 8'h00};
      #1;
      check("t6_grant", 32'(bus.req_rdy), 32'b0100);
      expect_word(2, t6_dat[k]);
      step();
    end
    bus.req_vld  = 4'b1111;
    bus.req_data = {4'h4, 4'h3, 4'h2, 4'h1};
    #1;
    rstN = 1'b0;
    #1;
    check("t6_rst_vld",  32'(bus.out_vld),  32'd0);
    check("t6_rst_data", 32'(bus.out_data), 32'd0);
    check("t6_rst_rdy",  32'(bus.req_rdy),  32'd0);
    check("t6_rst_wen",  32'(bus.write_en), 32'd0);
    check("t6_rst_ren",  32'(bus.read_en),  32'd0);
    check("t6_rst_idle", 32'(idle),         32'd1);
    exp_q.delete();
    @(posedge clk);
    #3 rstN = 1'b1;
    #1;
    check("t6_first_grant", 32'(bus.req_rdy), 32'b0001);
    expect_word(0, 4'h1);
    bus.out_rdy = 1'b1;
    step();
    bus.req_vld = '0;
    drain("t6_drain");
    check("t6_sync_err", 32'(sync_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
